// File: rtl/sdram_arb_pkg.sv
// Shared SDRAM parameters: address geometry, arbiter defaults, state encoding.
// Optional watchdog in the arbiter is enabled with SDRAM_ARB_TIMEOUT_EN.
package sdram_arb_pkg;

    localparam int SDRAM_BANK_W = 2;
    localparam int SDRAM_ROW_W  = 12;
    localparam int SDRAM_COL_W  = 9;

    localparam int ARB_ADDR_W  = SDRAM_BANK_W + SDRAM_ROW_W + SDRAM_COL_W;
    localparam int ARB_TIMEOUT = 511;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REF  = 2'd1,
        ARB_WR   = 2'd2,
        ARB_RD   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/sdram_arb_wdog.sv
// Transaction watchdog: counts busy cycles, flags expiry at LIMIT.
// Only instantiated when SDRAM_ARB_TIMEOUT_EN is defined.
module sdram_arb_wdog
    import sdram_arb_pkg::*;
#(
    parameter int LIMIT = ARB_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic expire
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || !run || clr) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Fires on the LIMIT-th busy cycle unless the command finishes then.
    assign expire = run && !clr && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/sdram_arb.sv
// SDRAM command arbiter: refresh first, then round-robin read/write.
// Define SDRAM_ARB_TIMEOUT_EN for the watchdog and sticky arb_err output.
module sdram_arb
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W  = ARB_ADDR_W,
    parameter int TIMEOUT = ARB_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_done,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              wr_ack,
    output logic              rd_ack,
    input  logic              sdram_ref_req,
    input  logic              ref_domain,
    output logic              sdram_ref_ack,
    output logic              ref_start,
    output logic              sdram_wr_req,
    output logic              sdram_rd_req,
    output logic [ADDR_W-1:0] sdram_addr,
    input  logic              cmd_done,
    output logic              busy
`ifdef SDRAM_ARB_TIMEOUT_EN
    , output logic            arb_err
`endif
);

    arb_state_e state;
    logic       rr_wr;
    logic       rw_ok;
    logic       pick_wr;
    logic       expire;

    assign busy    = (state != ARB_IDLE);
    assign rw_ok   = !ref_domain;
    assign pick_wr = wr_req && (!rd_req || rr_wr);

`ifdef SDRAM_ARB_TIMEOUT_EN
    sdram_arb_wdog #(
        .LIMIT (TIMEOUT)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .run    (busy),
        .clr    (cmd_done),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            arb_err <= 1'b0;
        end else if (expire) begin
            arb_err <= 1'b1;
        end
    end
`else
    // No watchdog: owner states wait for cmd_done forever.
    assign expire = (TIMEOUT < 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ARB_IDLE;
            rr_wr         <= 1'b1;
            wr_ack        <= 1'b0;
            rd_ack        <= 1'b0;
            sdram_ref_ack <= 1'b0;
            ref_start     <= 1'b0;
            sdram_wr_req  <= 1'b0;
            sdram_rd_req  <= 1'b0;
            sdram_addr    <= '0;
        end else begin
            wr_ack        <= 1'b0;
            rd_ack        <= 1'b0;
            sdram_ref_ack <= 1'b0;
            unique case (state)
                ARB_IDLE: begin
                    if (!init_done) begin
                        state <= ARB_IDLE;
                    end else if (sdram_ref_req) begin
                        state         <= ARB_REF;
                        sdram_ref_ack <= 1'b1;
                        ref_start     <= 1'b1;
                    end else if (rw_ok && pick_wr) begin
                        state        <= ARB_WR;
                        wr_ack       <= 1'b1;
                        sdram_wr_req <= 1'b1;
                        sdram_addr   <= wr_addr;
                        rr_wr        <= !rr_wr;
                    end else if (rw_ok && rd_req) begin
                        state        <= ARB_RD;
                        rd_ack       <= 1'b1;
                        sdram_rd_req <= 1'b1;
                        sdram_addr   <= rd_addr;
                        rr_wr        <= !rr_wr;
                    end
                end
                ARB_REF, ARB_WR, ARB_RD: begin
                    if (cmd_done || expire) begin
                        state        <= ARB_IDLE;
                        ref_start    <= 1'b0;
                        sdram_wr_req <= 1'b0;
                        sdram_rd_req <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arb.sv
// Bench for sdram_arb: directed scenarios plus random traffic vs a model.
// Build with SDRAM_ARB_TIMEOUT_EN to also exercise the watchdog.
module tb_sdram_arb;

    localparam int AW = 23;
    localparam int TO = 40;
`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, init_done, wr_req, rd_req;
    logic [AW-1:0] wr_addr, rd_addr, sdram_addr;
    logic          wr_ack, rd_ack, sdram_ref_req, ref_domain;
    logic          sdram_ref_ack, ref_start, sdram_wr_req, sdram_rd_req;
    logic          cmd_done, busy;
    logic          arb_err;

    always #5 clk = ~clk;

    sdram_arb #(
        .ADDR_W  (AW),
        .TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .init_done     (init_done),
        .wr_req        (wr_req),
        .wr_addr       (wr_addr),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .wr_ack        (wr_ack),
        .rd_ack        (rd_ack),
        .sdram_ref_req (sdram_ref_req),
        .ref_domain    (ref_domain),
        .sdram_ref_ack (sdram_ref_ack),
        .ref_start     (ref_start),
        .sdram_wr_req  (sdram_wr_req),
        .sdram_rd_req  (sdram_rd_req),
        .sdram_addr    (sdram_addr),
        .cmd_done      (cmd_done),
        .busy          (busy)
`ifdef SDRAM_ARB_TIMEOUT_EN
        , .arb_err     (arb_err)
`endif
    );

`ifndef SDRAM_ARB_TIMEOUT_EN
    assign arb_err = 1'b0;
`endif

    int checks = 0;
    int passes = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: who owns the SDRAM (0 none, 1 refresh, 2 write, 3 read)
    int            m_own;
    int            m_age;
    bit            m_wr_ack, m_rd_ack, m_ref_ack, m_rr_wr, m_err;
    logic [AW-1:0] m_addr;

    task automatic model_step();
        bit gw;
        m_wr_ack  = 1'b0;
        m_rd_ack  = 1'b0;
        m_ref_ack = 1'b0;
        if (rst) begin
            m_own = 0; m_age = 0; m_addr = '0;
            m_rr_wr = 1'b1; m_err = 1'b0;
        end else if (m_own != 0) begin
            m_age++;
            if (cmd_done) m_own = 0;
            else if (TO_EN && m_age >= TO) begin
                m_own = 0; m_err = 1'b1;
            end
        end else if (init_done) begin
            if (sdram_ref_req) begin
                m_own = 1; m_ref_ack = 1'b1; m_age = 0;
            end else if (!ref_domain && (wr_req || rd_req)) begin
                gw = wr_req && (!rd_req || m_rr_wr);
                m_own = gw ? 2 : 3;
                m_addr = gw ? wr_addr : rd_addr;
                if (gw) m_wr_ack = 1'b1;
                else m_rd_ack = 1'b1;
                m_rr_wr = !m_rr_wr;
                m_age = 0;
            end
        end
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (chk_on) begin
            chk("wr_ack", wr_ack, m_wr_ack);
            chk("rd_ack", rd_ack, m_rd_ack);
            chk("ref_ack", sdram_ref_ack, m_ref_ack);
            chk("ref_start", ref_start, m_own == 1);
            chk("sdram_wr_req", sdram_wr_req, m_own == 2);
            chk("sdram_rd_req", sdram_rd_req, m_own == 3);
            chk("busy", busy, m_own != 0);
            chk("sdram_addr", sdram_addr, m_addr);
            if (TO_EN) chk("arb_err", arb_err, m_err);
            chk("one_owner", 32'(ref_start) + 32'(sdram_wr_req) + 32'(sdram_rd_req) <= 1, 1);
        end
    end

    task automatic nxt();
        @(negedge clk);
        cmd_done = 1'b0;
        if (wr_ack) wr_req = 1'b0;
        if (rd_ack) rd_req = 1'b0;
        if (sdram_ref_ack) sdram_ref_req = 1'b0;
    endtask

    // which: 0 write, 1 read, 2 refresh, 3 write or read
    task automatic wait_ack(input int which, output int n);
        for (n = 1; n <= 300; n++) begin
            nxt();
            if ((which == 0 || which == 3) && wr_ack) return;
            if ((which == 1 || which == 3) && rd_ack) return;
            if (which == 2 && sdram_ref_ack) return;
        end
        checks++;
        $display("FAIL wait_ack(%0d): no ack within 300 cycles", which);
    endtask

    task automatic count_acks(input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            nxt();
            cnt += int'(wr_ack) + int'(rd_ack);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ctl"}, {wr_ack, rd_ack, sdram_ref_ack, ref_start,
                            sdram_wr_req, sdram_rd_req, busy}, 0);
        chk({tag, "_addr"}, sdram_addr, 0);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        nxt(); nxt();
        rst = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, k, cnt;
        logic [3:0] seq;
        rst = 1'b1; init_done = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
        wr_addr = '0; rd_addr = '0; sdram_ref_req = 1'b0;
        ref_domain = 1'b0; cmd_done = 1'b0;
        nxt();
        chk_on = 1'b1;
        nxt();
        chk_quiet("reset");
        rst = 1'b0;

        // No grants before init, then first write one cycle after init_done
        wr_req = 1'b1; wr_addr = 23'h12345;
        count_acks(50, cnt);
        chk("no_ack_before_init", cnt, 0);
        init_done = 1'b1;
        wait_ack(0, n);
        chk("init_to_ack", n, 1);
        chk("wr_addr_loaded", sdram_addr, 23'h12345);
        repeat (5) nxt();
        chk("wr_level_held", sdram_wr_req, 1);
        cmd_done = 1'b1;
        nxt();
        chk("idle_after_done", busy, 0);

        // Round robin W,R,W,R with one idle cycle between grants
        reset_dut();
        wr_addr = 23'h00aaa; rd_addr = 23'h00bbb;
        wr_req = 1'b1; rd_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_ack(3, n);
            seq[i] = wr_ack;
            chk("rr_gap", n, (i == 0) ? 1 : 2);
            wr_req = (i < 3); rd_req = (i < 3);
            repeat (9) nxt();
            cmd_done = 1'b1;
        end
        chk("rr_sequence", seq, 4'b0101);
        nxt(); nxt();

        // Refresh raised mid-write waits, then beats the pending read
        reset_dut();
        wr_req = 1'b1; wr_addr = 23'h7f001;
        wait_ack(0, n);
        rd_req = 1'b1; rd_addr = 23'h00321;
        repeat (3) nxt();
        sdram_ref_req = 1'b1;
        repeat (5) nxt();
        cmd_done = 1'b1;
        wait_ack(2, n);
        chk("ref_after_done", n, 2);
        chk("rd_still_pending", rd_req, 1);
        repeat (3) nxt();
        cmd_done = 1'b1;
        wait_ack(1, n);
        chk("rd_after_ref", n, 2);
        chk("rd_addr_loaded", sdram_addr, 23'h00321);
        cmd_done = 1'b1;
        nxt(); nxt();

        // ref_domain blocks reads until it clears
        reset_dut();
        ref_domain = 1'b1; rd_req = 1'b1; rd_addr = 23'h01234;
        count_acks(20, cnt);
        chk("ref_domain_block", cnt, 0);
        sdram_ref_req = 1'b1;
        wait_ack(2, n);
        chk("ref_in_domain", n, 1);
        repeat (3) nxt();
        cmd_done = 1'b1;
        count_acks(6, cnt);
        chk("still_blocked", cnt, 0);
        ref_domain = 1'b0;
        wait_ack(1, n);
        chk("rd_after_domain", n, 1);
        cmd_done = 1'b1;
        nxt(); nxt();

        // Reset in the middle of a read
        reset_dut();
        rd_req = 1'b1; rd_addr = 23'h05555;
        wait_ack(1, n);
        repeat (2) nxt();
        rst = 1'b1;
        nxt();
        chk_quiet("mid_rd_reset");
        rst = 1'b0; rd_req = 1'b1;
        wait_ack(1, n);
        chk("rd_after_reset", n, 1);
        cmd_done = 1'b1;
        nxt(); nxt();

`ifdef SDRAM_ARB_TIMEOUT_EN
        // Missing cmd_done: watchdog aborts after TO busy cycles
        reset_dut();
        wr_req = 1'b1;
        wait_ack(0, n);
        for (k = 0; k < 500 && busy; k++) nxt();
        chk("timeout_cycles", k, TO);
        chk("arb_err_set", arb_err, 1);
        wr_req = 1'b1;
        wait_ack(0, n);
        cmd_done = 1'b1;
        nxt();
        chk("arb_err_sticky", arb_err, 1);
`endif

        // Random traffic against the model
        reset_dut();
        for (int c = 0; c < 3000; c++) begin
            nxt();
            rst = ($urandom_range(399) == 0);
            init_done = (c > 30) || ($urandom_range(3) == 0);
            if (!wr_req && $urandom_range(3) == 0) begin
                wr_req = 1'b1; wr_addr = AW'($urandom);
            end else if (wr_req && $urandom_range(39) == 0) begin
                wr_req = 1'b0;
            end
            if (!rd_req && $urandom_range(3) == 0) begin
                rd_req = 1'b1; rd_addr = AW'($urandom);
            end else if (rd_req && $urandom_range(39) == 0) begin
                rd_req = 1'b0;
            end
            if (!sdram_ref_req && $urandom_range(29) == 0) sdram_ref_req = 1'b1;
            if ($urandom_range(19) == 0) ref_domain = !ref_domain;
            cmd_done = ($urandom_range(7) == 0);
        end
        rst = 1'b0;
        nxt();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
